// File: rtl/rv64i_pkg.sv
// Shared RV64I front-end types: widths, fetch-unit state encoding, NOP.
// Imported by the fetch unit and its skid buffer.
package rv64i_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } ifu_state_e;
endpackage

// File: rtl/if_fetch_unit_skid.sv
// Single-entry {inst,pc,err} holding register used while decode stalls.
// Loads only on i_load; holds otherwise.
module ifu_skid_buf
  import rv64i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [ILEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_err,
  output logic [ILEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_err
);
  logic [ILEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;
  logic            r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst <= NOP_INST;
      r_pc   <= '0;
      r_err  <= 1'b0;
    end else if (i_load) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
      r_err  <= i_err;
    end
  end

  assign o_inst = r_inst;
  assign o_pc   = r_pc;
  assign o_err  = r_err;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch engine: one outstanding imem request, skid hold, flush drop.
// Optional IFU_MISALIGN_CHECK_EN faults misaligned PCs without a request.
module if_fetch_unit
  import rv64i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            waiting_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o,
  output logic            misalign_o
);
  ifu_state_e      r_state;
  ifu_state_e      w_next;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inst_valid;
  logic [ILEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_fault;
  logic            r_mis;

  logic            w_mis_pc;
  logic            w_req_valid;
  logic            w_acc;
  logic            w_wait;
  logic            w_dlv;
  logic            w_mis_dlv;
  logic            w_skid_load;
  logic [ILEN-1:0] w_d_inst;
  logic [XLEN-1:0] w_d_pc;
  logic            w_d_err;
  logic [ILEN-1:0] w_sk_inst;
  logic [XLEN-1:0] w_sk_pc;
  logic            w_sk_err;

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_mis_pc = |pc_i[1:0];
`else
  assign w_mis_pc = 1'b0;
`endif

  ifu_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_skid_load),
    .i_inst (imem_rsp_data_i),
    .i_pc   (r_req_pc),
    .i_err  (imem_rsp_err_i),
    .o_inst (w_sk_inst),
    .o_pc   (w_sk_pc),
    .o_err  (w_sk_err)
  );

  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_acc       = 1'b0;
    w_wait      = 1'b1;
    w_dlv       = 1'b0;
    w_mis_dlv   = 1'b0;
    w_skid_load = 1'b0;
    w_d_inst    = imem_rsp_data_i;
    w_d_pc      = r_req_pc;
    w_d_err     = imem_rsp_err_i;
    unique case (r_state)
      S_REQ: begin
        if (!flush_i) begin
          if (w_mis_pc) begin
            w_dlv     = 1'b1;
            w_mis_dlv = 1'b1;
            w_d_pc    = pc_i;
            w_d_err   = 1'b1;
            w_wait    = 1'b0;
          end else begin
            w_req_valid = 1'b1;
            if (imem_req_ready_i) begin
              w_acc  = 1'b1;
              w_next = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (flush_i) begin
            w_next = S_REQ;
          end else if (!stall_i) begin
            w_dlv  = 1'b1;
            w_wait = 1'b0;
            w_next = S_REQ;
          end else begin
            w_skid_load = 1'b1;
            w_next      = S_HOLD;
          end
        end else if (flush_i) begin
          w_next = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          w_next = S_REQ;
        end else if (!stall_i) begin
          w_dlv    = 1'b1;
          w_wait   = 1'b0;
          w_d_inst = w_sk_inst;
          w_d_pc   = w_sk_pc;
          w_d_err  = w_sk_err;
          w_next   = S_REQ;
        end
      end
      S_DROP: begin
        // The stale response retires the request even if a new flush lands.
        if (imem_rsp_valid_i) w_next = S_REQ;
      end
      default: w_next = S_REQ;
    endcase
    if (flush_i) w_wait = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_req_pc     <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= '0;
      r_fault      <= 1'b0;
      r_mis        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_inst_valid <= w_dlv;
      r_mis        <= w_mis_dlv;
      if (w_acc) r_req_pc <= pc_i;
      if (w_dlv) begin
        r_inst    <= w_d_err ? NOP_INST : w_d_inst;
        r_inst_pc <= w_d_pc;
        r_fault   <= w_d_err;
      end
    end
  end

  assign imem_req_valid_o = rst_n & w_req_valid;
  assign imem_req_addr_o  = pc_i;
  assign waiting_o        = ~rst_n | w_wait;
  assign inst_valid_o     = r_inst_valid;
  assign inst_o           = r_inst;
  assign inst_pc_o        = r_inst_pc;
  assign inst_fault_o     = r_fault;
  assign misalign_o       = r_mis;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Random-stimulus scoreboard bench for if_fetch_unit with a PC register,
// a latency-randomized imem responder and a delivery monitor.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import rv64i_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pc_i;
  logic            stall_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            waiting_o;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i = 1'b0;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i = 1'b0;
  logic [ILEN-1:0] imem_rsp_data_i = '0;
  logic            imem_rsp_err_i = 1'b0;
  logic            inst_valid_o;
  logic [ILEN-1:0] inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            inst_fault_o;
  logic            misalign_o;
  logic [XLEN-1:0] tgt = '0;

  if_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_i             (pc_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .waiting_o        (waiting_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_fault_o     (inst_fault_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  // PC register: advances (or redirects) only when the fetch unit releases it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_i <= '0;
    else if (!waiting_o) pc_i <= flush_i ? tgt : pc_i + 64'd4;
  end

  typedef struct {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
    logic            mis;
  } exp_t;

  exp_t            q[$];
  exp_t            e_m;
  int              n_chk = 0;
  int              n_pass = 0;
  int              ndlv = 0;
  bit              outst = 0;
  bit              killed = 0;
  logic [XLEN-1:0] oaddr = '0;
  int              lat = 0;
  logic [XLEN-1:0] exp_next = '0;
  bit              last_stall = 0;
  bit              prev_iv = 0;
  bit              prev_pend = 0;
  logic [XLEN-1:0] prev_addr = '0;
  int              p_stall = 0;
  int              p_flush = 0;
  int              p_ready = 0;
  int              p_err = 0;
  int              lat_max = 0;
  bit              hold_rsp = 0;
  bit              f_force = 0;
  logic [XLEN-1:0] f_tgt = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  function automatic logic [ILEN-1:0] mem(logic [XLEN-1:0] a);
    if (a == '0) return 32'h00500093;
    return a[31:0] ^ 32'h9e3779b9;
  endfunction

  // One cycle: drive at negedge, then account for what the next edge does
  task automatic step();
    bit acc;
    @(negedge clk);
    if (outst && !hold_rsp && lat == 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_err_i   = ($urandom_range(0, 99) < p_err);
      imem_rsp_data_i  = mem(oaddr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_err_i   = 1'b0;
      imem_rsp_data_i  = $urandom;
      if (outst && lat > 0) lat--;
    end
    stall_i = ($urandom_range(0, 99) < p_stall);
    if (f_force) begin
      flush_i = 1'b1;
      tgt     = f_tgt;
      f_force = 0;
    end else begin
      flush_i = ($urandom_range(0, 99) < p_flush);
      tgt     = {54'd0, 8'($urandom), 2'b00};
    end
    imem_req_ready_i = ($urandom_range(0, 99) < p_ready);
    #1;
    last_stall = stall_i;
    acc = imem_req_valid_o && imem_req_ready_i;
    if (imem_req_valid_o) chk("req_addr", imem_req_addr_o, pc_i);
    if (prev_pend && imem_req_valid_o)
      chk("addr_stable", imem_req_addr_o, prev_addr);
    if (imem_req_valid_o && !imem_req_ready_i)
      chk("wait_while_pending", waiting_o, 64'd1);
    prev_pend = imem_req_valid_o && !imem_req_ready_i;
    prev_addr = imem_req_addr_o;
`ifdef IFU_MISALIGN_CHECK_EN
    if (pc_i[1:0] != 2'b00 && !outst && q.size() == 0 && !flush_i) begin
      chk("mis_no_req", imem_req_valid_o, 64'd0);
      chk("mis_release", waiting_o, 64'd0);
      q.push_back('{NOP_INST, pc_i, 1'b1, 1'b1});
    end
`endif
    if (imem_rsp_valid_i) begin
      if (!killed && !flush_i)
        q.push_back('{imem_rsp_err_i ? NOP_INST : imem_rsp_data_i,
                      oaddr, imem_rsp_err_i, 1'b0});
      outst = 0;
    end
    // a flush discards everything fetched but not yet delivered
    if (flush_i) begin
      q.delete();
      if (outst) killed = 1;
      exp_next = tgt;
    end
    if (acc) begin
      outst  = 1;
      killed = 0;
      oaddr  = pc_i;
      lat    = $urandom_range(0, lat_max);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && inst_valid_o) begin
      if (!misalign_o) begin
        chk("stall_respected", last_stall, 64'd0);
        chk("pulse_width", prev_iv, 64'd0);
      end
      chk("pc_sequence", inst_pc_o, exp_next);
      if (q.size() == 0) begin
        chk("unexpected_delivery", inst_pc_o, 64'hffff_ffff_ffff_ffff);
      end else begin
        e_m = q.pop_front();
        chk("inst", inst_o, e_m.inst);
        chk("inst_pc", inst_pc_o, e_m.pc);
        chk("fault", inst_fault_o, e_m.fault);
        chk("misalign", misalign_o, e_m.mis);
      end
      exp_next = inst_pc_o + 64'd4;
      ndlv++;
    end
    prev_iv = rst_n && inst_valid_o;
  end

  task automatic check_reset(string tag);
    chk({tag, "_valid"}, inst_valid_o, 64'd0);
    chk({tag, "_inst"}, inst_o, NOP_INST);
    chk({tag, "_pc"}, inst_pc_o, 64'd0);
    chk({tag, "_fault"}, inst_fault_o, 64'd0);
    chk({tag, "_mis"}, misalign_o, 64'd0);
    chk({tag, "_req"}, imem_req_valid_o, 64'd0);
    chk({tag, "_wait"}, waiting_o, 64'd1);
  endtask

  task automatic drain();
    p_stall = 0;
    p_flush = 0;
    p_ready = 0;
    for (int i = 0; i < 60 && (outst || q.size() != 0); i++) step();
    repeat (2) step();
    chk("drain_queue", q.size(), 64'd0);
    chk("drain_outstanding", outst, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    p_ready = 100;
    lat_max = 0;
    step();
    step();
    chk("t1_wait_low", waiting_o, 64'd0);
    step();
    chk("t1_valid", inst_valid_o, 64'd1);
    chk("t1_inst", inst_o, 64'h00500093);
    chk("t1_next_addr", imem_req_addr_o, 64'h4);
    chk("t1_wait_high", waiting_o, 64'd1);

    p_stall = 30;
    p_flush = 5;
    p_ready = 60;
    p_err   = 10;
    lat_max = 3;
    repeat (3000) step();
    drain();
    chk("activity", ndlv > 100, 64'd1);

`ifdef IFU_MISALIGN_CHECK_EN
    f_force = 1;
    f_tgt   = 64'h6;
    step();
    p_ready = 100;
    lat_max = 0;
    step();
    step();
    chk("t6_mis", misalign_o, 64'd1);
    chk("t6_pc", inst_pc_o, 64'h6);
    chk("t6_fault", inst_fault_o, 64'd1);
    f_force = 1;
    f_tgt   = 64'h100;
    repeat (4) step();
    drain();
`endif

    p_ready  = 100;
    lat_max  = 0;
    hold_rsp = 1;
    for (int i = 0; i < 10 && !outst; i++) step();
    chk("mid_wait_outstanding", outst, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    q.delete();
    outst    = 0;
    killed   = 0;
    exp_next = '0;
    hold_rsp = 0;
    prev_pend = 0;
    #1 rst_n = 1'b1;
    p_ready = 100;
    repeat (6) step();
    chk("post_reset_fetch", ndlv > 0, 64'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
